// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl : decode-side scoreboard, stall/flush/bubble control  (rev 1.0)
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int NREG      = 64,
  parameter int FLUSH_CYC = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [31:0]      id_inst,
  input  logic             wb_rw,
  input  logic [5:0]       wb_rd,
  input  logic             br_taken,
  input  logic             mem_busy,
  output logic             svpc,
  output logic             if_stall,
  output logic             id_stall,
  output logic             id_flush,
  output logic             ex_bubble,
  output logic             issue,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_INC  = 4'b0101;
  localparam logic [3:0] OP_NEG  = 4'b0110;
  localparam logic [3:0] OP_SUB  = 4'b0111;
  localparam logic [3:0] OP_J    = 4'b1000;
  localparam logic [3:0] OP_BRZ  = 4'b1001;
  localparam logic [3:0] OP_JM   = 4'b1010;
  localparam logic [3:0] OP_BRN  = 4'b1011;
  localparam logic [3:0] OP_LD   = 4'b1110;
  localparam logic [3:0] OP_SVPC = 4'b1111;

  typedef enum logic [1:0] {S_RUN, S_HAZ, S_FLUSH} state_t;

  state_t            state_q, state_d;
  logic [2:0]        flush_ctr_q, flush_ctr_d;
  logic [NREG-1:0]   pend_q, pend_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic [3:0] w_op;
  logic [5:0] w_rd, w_rs, w_rt;
  logic       w_wr, w_rs_rd, w_rt_rd, w_hazard, w_cnt_inc;
  logic       unused_inst;

  assign w_op        = id_inst[31:28];
  assign w_rd        = id_inst[27:22];
  assign w_rs        = id_inst[21:16];
  assign w_rt        = id_inst[15:10];
  assign unused_inst = ^id_inst[9:0];
  assign svpc        = (w_op == OP_SVPC);

  always_comb begin
    w_wr    = 1'b0;
    w_rs_rd = 1'b0;
    w_rt_rd = 1'b0;
    case (w_op)
      OP_SVPC:                        w_wr = 1'b1;
      OP_LD:                          begin w_wr = 1'b1; w_rs_rd = 1'b1; end
      OP_INC, OP_NEG:                 begin w_wr = 1'b1; w_rs_rd = 1'b1; end
      OP_ADD, OP_SUB:                 begin w_wr = 1'b1; w_rs_rd = 1'b1; w_rt_rd = 1'b1; end
      OP_ST:                          begin w_rs_rd = 1'b1; w_rt_rd = 1'b1; end
      OP_J, OP_BRZ, OP_JM, OP_BRN:    w_rs_rd = 1'b1;
      default: ;
    endcase
  end

  // Registered pend only: a same-cycle writeback clear releases the stall next cycle.
  assign w_hazard = id_valid & ((w_rs_rd & pend_q[w_rs]) |
                                (w_rt_rd & pend_q[w_rt]) |
                                (w_wr    & pend_q[w_rd]));

  always_comb begin
    state_d     = state_q;
    flush_ctr_d = flush_ctr_q;
    if_stall    = 1'b0;
    id_stall    = 1'b0;
    id_flush    = 1'b0;
    ex_bubble   = 1'b0;
    issue       = 1'b0;
    w_cnt_inc   = 1'b0;

    if (br_taken) begin
      state_d     = (FLUSH_CYC > 1) ? S_FLUSH : S_RUN;
      flush_ctr_d = 3'(FLUSH_CYC - 1);
    end else if (mem_busy) begin
      state_d     = state_q;
    end else if (state_q == S_FLUSH) begin
      if (flush_ctr_q <= 3'd1) begin
        state_d     = S_RUN;
        flush_ctr_d = 3'd0;
      end else begin
        flush_ctr_d = flush_ctr_q - 3'd1;
      end
    end else begin
      state_d = w_hazard ? S_HAZ : S_RUN;
    end

    if (state_q == S_FLUSH || br_taken) begin
      id_flush  = 1'b1;
      ex_bubble = 1'b1;
    end else if (mem_busy) begin
      if_stall  = 1'b1;
      id_stall  = 1'b1;
    end else if (w_hazard) begin
      if_stall  = 1'b1;
      id_stall  = 1'b1;
      ex_bubble = 1'b1;
      w_cnt_inc = 1'b1;
    end else begin
      issue     = id_valid;
    end
  end

  always_comb begin
    pend_d = pend_q;
    if (wb_rw)         pend_d[wb_rd] = 1'b0;
    if (issue && w_wr) pend_d[w_rd]  = 1'b1;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (w_cnt_inc && stall_cnt_q != {CNT_W{1'b1}})
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      flush_ctr_q <= 3'd0;
      pend_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_ctr_q <= flush_ctr_d;
      pend_q      <= pend_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// tb_pipe_hazard_ctrl : directed + randomized check of pipe_hazard_ctrl against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int FLUSH_CYC = 2;
  localparam int CNT_W     = 4;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             id_valid = 1'b0;
  logic [31:0]      id_inst = '0;
  logic             wb_rw = 1'b0;
  logic [5:0]       wb_rd = '0;
  logic             br_taken = 1'b0;
  logic             mem_busy = 1'b0;
  logic             svpc, if_stall, id_stall, id_flush, ex_bubble, issue;
  logic [CNT_W-1:0] stall_cnt;

  pipe_hazard_ctrl #(.NREG(64), .FLUSH_CYC(FLUSH_CYC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_inst(id_inst),
    .wb_rw(wb_rw), .wb_rd(wb_rd), .br_taken(br_taken), .mem_busy(mem_busy),
    .svpc(svpc), .if_stall(if_stall), .id_stall(id_stall), .id_flush(id_flush),
    .ex_bubble(ex_bubble), .issue(issue), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Model: pending-register set, remaining flush cycles after this one, stall count.
  bit   m_pend [64];
  int   m_flush_left;
  int   m_cnt;
  logic [3:0] m_op;
  logic [5:0] m_rd;
  bit   m_inc;
  logic e_svpc, e_if, e_id, e_fl, e_bub, e_iss;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic bit is_wr(input logic [3:0] op);
    return op inside {4'hF, 4'hE, 4'h4, 4'h5, 4'h6, 4'h7};
  endfunction
  function automatic bit is_rs(input logic [3:0] op);
    return op inside {4'hE, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB};
  endfunction
  function automatic bit is_rt(input logic [3:0] op);
    return op inside {4'h3, 4'h4, 4'h7};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_pend[i] = 1'b0;
    m_flush_left = 0;
    m_cnt        = 0;
  endtask

  task automatic model_eval();
    logic [5:0] rs, rt;
    bit haz;
    m_op = id_inst[31:28];
    m_rd = id_inst[27:22];
    rs   = id_inst[21:16];
    rt   = id_inst[15:10];
    haz  = id_valid && ((is_rs(m_op) && m_pend[rs]) || (is_rt(m_op) && m_pend[rt]) ||
                        (is_wr(m_op) && m_pend[m_rd]));
    e_svpc = (m_op == 4'hF);
    {e_if, e_id, e_fl, e_bub, e_iss} = '0;
    m_inc = 1'b0;
    if (m_flush_left > 0 || br_taken) begin
      e_fl = 1'b1; e_bub = 1'b1;
    end else if (mem_busy) begin
      e_if = 1'b1; e_id = 1'b1;
    end else if (haz) begin
      e_if = 1'b1; e_id = 1'b1; e_bub = 1'b1; m_inc = 1'b1;
    end else begin
      e_iss = id_valid;
    end
  endtask

  task automatic model_update();
    if (wb_rw) m_pend[wb_rd] = 1'b0;
    if (e_iss && is_wr(m_op)) m_pend[m_rd] = 1'b1;
    if (m_inc && m_cnt < CNT_MAX) m_cnt++;
    if (br_taken) m_flush_left = FLUSH_CYC - 1;
    else if (!mem_busy && m_flush_left > 0) m_flush_left--;
  endtask

  task automatic sample();
    @(negedge clk);
    model_eval();
    chk("svpc",      svpc,      e_svpc);
    chk("if_stall",  if_stall,  e_if);
    chk("id_stall",  id_stall,  e_id);
    chk("id_flush",  id_flush,  e_fl);
    chk("ex_bubble", ex_bubble, e_bub);
    chk("issue",     issue,     e_iss);
    chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst_n) model_update();
    #1;
  endtask

  task automatic put(input logic v, input logic [3:0] op, input logic [5:0] rd,
                     input logic [5:0] rs, input logic [5:0] rt);
    id_valid = v;
    id_inst  = {op, rd, rs, rt, 10'($urandom)};
  endtask

  initial begin
    int c_before;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset asserted mid-flush with a pending register
    put(1, 4'h4, 6'd12, 6'd1, 6'd2); sample(); advance();
    put(0, 4'h0, 0, 0, 0); br_taken = 1'b1; sample(); advance();
    br_taken = 1'b0;
    #2 rst_n = 1'b0; model_reset();
    sample();
    chk("rst_id_flush", id_flush, 1'b0);
    chk("rst_if_stall", if_stall, 1'b0);
    chk("rst_issue",    issue,    1'b0);
    chk("rst_cnt",      32'(stall_cnt), 32'd0);
    advance();
    rst_n = 1'b1;
    put(1, 4'h4, 6'd13, 6'd12, 6'd12); sample();
    chk("rst_pend_clear_issue", issue, 1'b1);
    advance();

    // RAW
    put(1, 4'h4, 6'd5, 6'd1, 6'd2); sample();
    chk("raw_add_issue", issue, 1'b1);
    advance();
    put(1, 4'h7, 6'd7, 6'd5, 6'd2); sample();
    chk("raw_if_stall", if_stall, 1'b1);
    chk("raw_bubble",   ex_bubble, 1'b1);
    chk("raw_cnt0",     32'(stall_cnt), 32'd0);
    advance(); sample();
    chk("raw_cnt1", 32'(stall_cnt), 32'd1);
    advance();
    wb_rw = 1'b1; wb_rd = 6'd5; sample();
    chk("raw_wb_still_stall", id_stall, 1'b1);
    chk("raw_cnt2", 32'(stall_cnt), 32'd2);
    advance(); wb_rw = 1'b0; sample();
    chk("raw_release_issue", issue, 1'b1);
    advance();

    // WAW with SVPC
    put(1, 4'hE, 6'd3, 6'd1, 6'd0); sample(); advance();
    put(1, 4'hF, 6'd3, 6'd0, 6'd0); sample();
    chk("waw_svpc", svpc, 1'b1);
    chk("waw_stall", id_stall, 1'b1);
    advance(); sample(); advance();
    wb_rw = 1'b1; wb_rd = 6'd3; sample();
    chk("waw_wb_still_stall", id_stall, 1'b1);
    advance(); wb_rw = 1'b0; sample();
    chk("waw_svpc_issue", issue, 1'b1);
    advance();
    put(1, 4'h4, 6'd9, 6'd3, 6'd0); sample();
    chk("svpc_set_pend3", id_stall, 1'b1);
    advance();
    put(0, 4'h0, 0, 0, 0); wb_rw = 1'b1; wb_rd = 6'd3; sample(); advance(); wb_rw = 1'b0;

    // Branch flush, then restart on flush cycle 2
    put(1, 4'h4, 6'd10, 6'd1, 6'd1); br_taken = 1'b1; sample();
    chk("br_flush_c1", id_flush, 1'b1);
    chk("br_issue_c1", issue, 1'b0);
    advance(); br_taken = 1'b0; sample();
    chk("br_flush_c2", id_flush, 1'b1);
    chk("br_bubble_c2", ex_bubble, 1'b1);
    advance(); put(0, 4'h4, 6'd10, 6'd1, 6'd1); sample();
    chk("br_flush_c3", id_flush, 1'b0);
    advance();
    put(1, 4'h4, 6'd10, 6'd1, 6'd1); br_taken = 1'b1; sample(); advance();
    sample(); advance();
    br_taken = 1'b0; sample();
    chk("br_restart_c2", id_flush, 1'b1);
    advance(); put(0, 4'h4, 6'd10, 6'd1, 6'd1); sample();
    chk("br_restart_end", id_flush, 1'b0);
    advance();
    put(1, 4'h7, 6'd11, 6'd10, 6'd10); sample();
    chk("br_no_pend", issue, 1'b1);
    advance();

    // Memory stall during a hazard, writeback during mem_busy
    put(1, 4'hE, 6'd6, 6'd1, 6'd0); sample(); advance();
    put(1, 4'h4, 6'd8, 6'd6, 6'd1); mem_busy = 1'b1; c_before = m_cnt; sample();
    chk("mem_if_stall", if_stall, 1'b1);
    chk("mem_bubble",   ex_bubble, 1'b0);
    advance();
    wb_rw = 1'b1; wb_rd = 6'd6; sample(); advance(); wb_rw = 1'b0;
    sample();
    chk("mem_cnt_hold", 32'(stall_cnt), 32'(c_before));
    advance(); mem_busy = 1'b0; sample();
    chk("mem_wb_cleared", issue, 1'b1);
    advance();

    // Saturation
    put(1, 4'h4, 6'd20, 6'd1, 6'd1); sample(); advance();
    put(1, 4'h7, 6'd21, 6'd20, 6'd20);
    repeat (20) begin sample(); advance(); end
    sample();
    chk("sat_cnt", 32'(stall_cnt), 32'd15);
    advance();
    put(0, 4'h0, 0, 0, 0); wb_rw = 1'b1; wb_rd = 6'd20; sample(); advance(); wb_rw = 1'b0;

    // Randomized phase from a fresh reset
    rst_n = 1'b0; model_reset(); sample(); advance(); rst_n = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      int start;
      put(($urandom_range(0, 9) < 7), 4'($urandom), 6'($urandom_range(0, 7)),
          6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)));
      br_taken = ($urandom_range(0, 19) == 0);
      mem_busy = ($urandom_range(0, 9) == 0);
      wb_rw    = 1'b0;
      if ($urandom_range(0, 2) == 0) begin
        start = int'($urandom_range(0, 7));
        for (int k = 0; k < 8; k++) begin
          if (!wb_rw && m_pend[(start + k) % 8]) begin
            wb_rw = 1'b1;
            wb_rd = 6'((start + k) % 8);
          end
        end
      end
      sample(); advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
